// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_rd_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR_I,
      ST_AR_D,
      ST_R_I,
      ST_R_D
   } arb_state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] DEF_ID_I   = 4'd0;
   localparam logic [3:0] DEF_ID_D   = 4'd1;

endpackage

// File: rtl/axi_rd_arbiter_rr_starve_ctr.sv
// Grant decision between icache and dcache read requests, with a starvation bound on the icache side.
// Latency: grant outputs are combinational from the requests; the counter updates on the grant edge.
// Backpressure: grants only while idle is high; a dcache request is not eligible while a write is unacknowledged.
// Ports: clk/rst; idle (arbiter can accept a new burst); i_arvalid, d_arvalid, wr_pending (requests);
//        grant_i, grant_d (one-hot or zero grant for this cycle).
module axi_rd_arbiter_rr_starve_ctr
   import axi_rd_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic i_arvalid,
   input  logic d_arvalid,
   input  logic wr_pending,
   output logic grant_i,
   output logic grant_d
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic          d_eligible;
   logic          starved;

   always_comb begin
      d_eligible = d_arvalid & ~wr_pending;
      starved    = (cnt_q == CW'(STARVE_LIMIT));
      // icache wins when it has waited long enough or dcache cannot go anyway
      grant_i    = idle & i_arvalid & (starved | ~d_eligible);
      grant_d    = idle & d_eligible & ~grant_i;
   end

   // Counts dcache grants that overtook a waiting icache request; saturates at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (grant_i) begin
         cnt_q <= '0;
      end else if (grant_d && i_arvalid && !starved) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R port between icache and dcache refills, one burst at a time, R beats steered to the owner.
// Latency: request seen in IDLE at cycle N drives arvalid at N+1; R path is combinational pass-through.
// Backpressure: rready mirrors the owner's rready; requesters hold their AR fields until x_arready pulses.
// Ports: clk/rst; i_ar*/i_r* icache side; d_ar*/d_r* dcache side; wr_pending blocks new dcache grants;
//        ar*/r* AXI master read port; rd_err sticky flag for error response or unexpected rid.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int         STARVE_LIMIT = 4,
   parameter logic [3:0] ID_I         = DEF_ID_I,
   parameter logic [3:0] ID_D         = DEF_ID_D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_araddr,
   input  logic [7:0]  i_arlen,
   input  logic [2:0]  i_arsize,
   input  logic        i_arvalid,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic        i_rlast,
   output logic        i_rvalid,
   input  logic        i_rready,
   input  logic [31:0] d_araddr,
   input  logic [7:0]  d_arlen,
   input  logic [2:0]  d_arsize,
   input  logic        d_arvalid,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic        d_rlast,
   output logic        d_rvalid,
   input  logic        d_rready,
   input  logic        wr_pending,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        rd_err
);

   arb_state_t  state_q, state_d;
   logic        grant_i, grant_d;
   logic        idle;
   logic [3:0]  arid_q;
   logic [31:0] araddr_q;
   logic [7:0]  arlen_q;
   logic [2:0]  arsize_q;
   logic        rd_err_q;
   logic        beat_err;

   assign idle = (state_q == ST_IDLE);

   axi_rd_arbiter_rr_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .idle       (idle),
      .i_arvalid  (i_arvalid),
      .d_arvalid  (d_arvalid),
      .wr_pending (wr_pending),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      arvalid   = 1'b0;
      i_arready = 1'b0;
      d_arready = 1'b0;
      rready    = 1'b0;
      i_rvalid  = 1'b0;
      i_rlast   = 1'b0;
      d_rvalid  = 1'b0;
      d_rlast   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_i) begin
               state_d = ST_AR_I;
            end else if (grant_d) begin
               state_d = ST_AR_D;
            end
         end
         ST_AR_I: begin
            arvalid   = 1'b1;
            i_arready = arready;
            if (arready) state_d = ST_R_I;
         end
         ST_AR_D: begin
            arvalid   = 1'b1;
            d_arready = arready;
            if (arready) state_d = ST_R_D;
         end
         ST_R_I: begin
            rready   = i_rready;
            i_rvalid = rvalid;
            i_rlast  = rlast;
            if (rvalid && i_rready && rlast) state_d = ST_IDLE;
         end
         ST_R_D: begin
            rready   = d_rready;
            d_rvalid = rvalid;
            d_rlast  = rlast;
            if (rvalid && d_rready && rlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Data is fanned out unconditionally; only valid/last are qualified by ownership.
   assign i_rdata = rdata;
   assign d_rdata = rdata;

   // An accepted beat with an error response or a foreign id is still delivered but flagged.
   assign beat_err = rvalid & rready & ((rresp != 2'b00) | (rid != arid_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arid_q   <= '0;
         araddr_q <= '0;
         arlen_q  <= '0;
         arsize_q <= '0;
         rd_err_q <= 1'b0;
      end else begin
         if (grant_i) begin
            arid_q   <= ID_I;
            araddr_q <= i_araddr;
            arlen_q  <= i_arlen;
            arsize_q <= i_arsize;
         end else if (grant_d) begin
            arid_q   <= ID_D;
            araddr_q <= d_araddr;
            arlen_q  <= d_arlen;
            arsize_q <= d_arsize;
         end
         if (beat_err) rd_err_q <= 1'b1;
      end
   end

   assign arid    = arid_q;
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arsize  = arsize_q;
   assign arburst = BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;
   assign rd_err  = rd_err_q;

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Read-channel arbiter that shares the single AXI AR/R port between the instruction cache (i_*) and data cache (d_*) burst refills.
- Issues one read burst at a time and steers R beats back to the owner.
- Data side has priority; a starvation counter bounds instruction-side wait.
- Data reads are held off while a data write is still unacknowledged, which keeps read-after-write ordering.
- Sits between i_cache/d_cache and the top-level AXI read ports, alongside the existing write path.

Parameters:
STARVE_LIMIT, 4, number of consecutive data-side grants after which a waiting instruction request must win.
ID_I, 4'd0, arid used for instruction bursts.
ID_D, 4'd1, arid used for data bursts.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_araddr  in  32  icache burst address
i_arlen  in  8  icache burst length-1
i_arsize  in  3  icache beat size
i_arvalid  in  1  icache request
i_arready  out  1  icache address accepted
i_rdata  out  32  beat data to icache
i_rlast  out  1  last beat to icache
i_rvalid  out  1  beat valid to icache
i_rready  in  1  icache beat ready
d_araddr, d_arlen, d_arsize, d_arvalid, d_arready, d_rdata, d_rlast, d_rvalid, d_rready  (same as i_*, for dcache)
wr_pending  in  1  dcache write issued with B not yet received
arid  out  4  AXI read id
araddr  out  32  AXI read address
arlen  out  8  AXI burst length
arsize  out  3  AXI size
arburst  out  2  fixed 2'b01 (INCR)
arlock  out  2  fixed 0
arcache  out  4  fixed 0
arprot  out  3  fixed 0
arvalid  out  1  AXI address valid
arready  in  1  AXI address ready
rid  in  4  AXI read id
rdata  in  32  AXI read data
rresp  in  2  AXI read response
rlast  in  1  AXI last beat
rvalid  in  1  AXI beat valid
rready  out  1  AXI beat ready
rd_err  out  1  sticky: nonzero rresp or unexpected rid seen

Behaviour:
- Reset values: state IDLE; arvalid=0, rready=0, i_/d_arready=0, i_/d_rvalid=0, rd_err=0, starve_cnt=0. The araddr/arlen/arsize/arid registers reset to 0.
- FSM states: IDLE, AR_I, AR_D, R_I, R_D.
- IDLE grant rule, evaluated each cycle:
  - d_eligible = d_arvalid & ~wr_pending.
  - If i_arvalid & (starve_cnt==STARVE_LIMIT | ~d_eligible) -> AR_I.
  - Else if d_eligible -> AR_D.
  - Else stay in IDLE.
  - On the grant edge, latch the winner's araddr, arlen and arsize, and set arid to ID_I or ID_D.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while i_arvalid=1.
  - Clears on an I grant.
  - Holds otherwise.
- AR_x:
  - arvalid=1 from registered values.
  - x_arready = arvalid & arready (combinational, one-cycle pulse).
  - On arvalid&arready -> R_x.
  - Requesters must hold their request fields stable until x_arready.
- R_x:
  - rready = x_rready; x_rvalid = rvalid; x_rdata = rdata; x_rlast = rlast.
  - The non-owner's rvalid and rlast are 0.
  - On rvalid&rready&rlast -> IDLE.
  - The earliest next grant is the cycle after the last beat, so there is one idle cycle between bursts.
- Latency: request seen in IDLE at cycle N -> arvalid at N+1.
- rd_err:
  - Sets on rvalid&rready with rresp!=0, or with rid != the granted id.
  - The beat is still forwarded; rd_err stays set until reset.
- wr_pending only gates new D grants. An in-flight D burst is not affected.
- Simultaneous i/d requests with wr_pending=1 -> I wins regardless of the counter.
- A request dropped before grant is not a protocol requirement. Callers hold arvalid until arready.
- Asynchronous reset asserted mid-burst: everything returns to reset values immediately and remaining beats are not tracked. Reset is system-wide.

Decomposition:
- Shared package: FSM state enum, AXI constants (BURST_INCR=2'b01), default IDs.
- One natural sub-module, rr_starve_ctr: the saturating starvation counter and grant decision logic.
- The FSM and steering stay in the top module.

Test Plan:
- D only: d_araddr=0x0000_1000, arlen=7, arready after 2 cycles, 8 beats -> arid=1, arlen=7, d_rvalid asserted 8 times, d_rlast on beat 8, i_rvalid=0 throughout, state back to IDLE.
- Both requesting continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- d_arvalid=1 with wr_pending=1 for 10 cycles, i idle -> arvalid stays 0. wr_pending falls -> arvalid=1 with arid=1 the next cycle.
- Backpressure: d_rready toggles 1,0,1,0 during a 4-beat burst -> rready mirrors it and all 4 beats are delivered in order with none lost.
- rresp=2'b10 on beat 2 of an I burst -> beat still forwarded, rd_err=1 and held through later bursts until rst.
- rst asserted during beat 3 of a D burst -> arvalid=0, rready=0 and d_rvalid=0 in the same cycle (async). After release, a new I request is granted normally.
